obi_mem_responder: RTL and testbench

- Parametrised OBI-style memory slave model used by the core testbench to serve either the instruction or the data port of the RISC-V core.
- Successor to the fixed 32-bit instr/data signal bundle: it actively responds to requests instead of exposing raw wires.
- Data width, depth, fixed response latency and outstanding-request limit are configurable.
- Adds injectable grant backpressure, out-of-range error responses and a backdoor preload port.

---
 rtl/obi_mem_responder.sv | 157 +++++++++++++++
 tb/tb_obi_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// ---------------------------------------------------------------------------
// obi_mem_responder
//
// OBI-style memory slave model. It serves one core port (instruction or data)
// with a fixed grant-to-response latency, a bounded number of outstanding
// requests, injectable grant backpressure, out-of-range error responses and a
// backdoor word-write port for preloading.
//
// Ports
//   clk            clock
//   rst_ni         asynchronous active-low reset
//   req_i          request valid
//   gnt_o          request accepted this cycle (combinational)
//   addr_i         byte address
//   we_i           1 = write, 0 = read
//   be_i           byte enables for writes
//   wdata_i        write data
//   rvalid_o       response valid, one-cycle pulse per accepted request
//   rdata_o        read data; 0 for writes, errors and idle cycles
//   err_o          out-of-range access, qualified by rvalid_o
//   stall_i        forces gnt_o low
//   bd_we_i        backdoor full-word write enable
//   bd_idx_i       backdoor word index
//   bd_wdata_i     backdoor write data
//   outstanding_o  accepted-but-unanswered request count
// ---------------------------------------------------------------------------
module obi_mem_responder #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst_ni,
  input  logic                               req_i,
  output logic                               gnt_o,
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic                               we_i,
  input  logic [DATA_W/8-1:0]                be_i,
  input  logic [DATA_W-1:0]                  wdata_i,
  output logic                               rvalid_o,
  output logic [DATA_W-1:0]                  rdata_o,
  output logic                               err_o,
  input  logic                               stall_i,
  input  logic                               bd_we_i,
  input  logic [$clog2(DEPTH)-1:0]           bd_idx_i,
  input  logic [DATA_W-1:0]                  bd_wdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam bit DEPTH_POW2 = ((1 << IDX_W) == DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              bd_in_range;
  logic              accept;

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  // Response pipeline: stage 0 is loaded at the accept edge, the last stage
  // drives the outputs. Stages that carry no response hold all-zero so the
  // outputs are naturally 0 whenever rvalid_o is low.
  logic [LATENCY-1:0] pipe_valid_reg;
  logic [LATENCY-1:0] pipe_err_reg;
  logic [DATA_W-1:0]  pipe_data_reg [LATENCY];

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  always_comb begin
    word_addr = addr_i >> OFF_W;
    in_range  = (word_addr < ADDR_W'(DEPTH));
    word_idx  = word_addr[IDX_W-1:0];
  end

  // With a power-of-two depth every backdoor index is valid; otherwise the
  // top of the index range has to be filtered out.
  generate
    if (DEPTH_POW2) begin : g_bd_pow2
      assign bd_in_range = 1'b1;
    end else begin : g_bd_npow2
      assign bd_in_range = (32'(bd_idx_i) < 32'(DEPTH));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Grant / accept. Only the registered count is used, so a response that
  // retires this cycle does not free a slot until the next cycle.
  // ------------------------------------------------------------------
  assign gnt_o  = req_i & ~stall_i & (count_reg < CNT_W'(MAX_OUTSTANDING)) & rst_ni;
  assign accept = req_i & gnt_o;

  // ------------------------------------------------------------------
  // Memory array (not reset). The backdoor write is placed last so it
  // overrides a bus write to the same word on the same edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) begin
          mem[word_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (bd_we_i && bd_in_range) begin
      mem[bd_idx_i] <= bd_wdata_i;
    end
  end

  // ------------------------------------------------------------------
  // Outstanding counter
  // ------------------------------------------------------------------
  always_comb begin
    count_next = count_reg + CNT_W'(accept) - CNT_W'(rvalid_o);
  end

  // ------------------------------------------------------------------
  // Response pipeline and counter state. The read in stage 0 is a
  // registered read, so it returns the word as it was before any write
  // landing on the same edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_reg <= '0;
      pipe_err_reg   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_data_reg[s] <= '0;
      end
      count_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= accept;
      pipe_err_reg[0]   <= accept & ~in_range;
      pipe_data_reg[0]  <= (accept && !we_i && in_range) ? mem[word_idx] : '0;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_err_reg[s]   <= pipe_err_reg[s-1];
        pipe_data_reg[s]  <= pipe_data_reg[s-1];
      end
      count_reg <= count_next;
    end
  end

  assign rvalid_o      = pipe_valid_reg[LATENCY-1];
  assign err_o         = pipe_err_reg[LATENCY-1];
  assign rdata_o       = pipe_data_reg[LATENCY-1];
  assign outstanding_o = count_reg;

endmodule

// File: tb/tb_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_obi_mem_responder
//
// Directed bench for obi_mem_responder. u_dut uses the default parameters
// (LATENCY=2, MAX_OUTSTANDING=2); u_dut1 uses MAX_OUTSTANDING=1 to exercise
// the outstanding limit. Inputs change 1 ns after the rising edge and outputs
// are sampled 1-2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_ni;

  // Main instance
  logic        req, gnt, we, rvalid, err, stall;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_wdata;
  logic [1:0]  outstanding;

  // Single-outstanding instance
  logic        req1, gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic [0:0]  outstanding1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  obi_mem_responder u_dut (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .gnt_o         (gnt),
    .addr_i        (addr),
    .we_i          (we),
    .be_i          (be),
    .wdata_i       (wdata),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .err_o         (err),
    .stall_i       (stall),
    .bd_we_i       (bd_we),
    .bd_idx_i      (bd_idx),
    .bd_wdata_i    (bd_wdata),
    .outstanding_o (outstanding)
  );

  // Always issues byte-enable-free writes so its responses are all-zero.
  obi_mem_responder #(.MAX_OUTSTANDING(1)) u_dut1 (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .req_i         (req1),
    .gnt_o         (gnt1),
    .addr_i        (32'h0),
    .we_i          (1'b1),
    .be_i          (4'h0),
    .wdata_i       (32'h0),
    .rvalid_o      (rvalid1),
    .rdata_o       (rdata1),
    .err_o         (err1),
    .stall_i       (1'b0),
    .bd_we_i       (1'b0),
    .bd_idx_i      (10'd0),
    .bd_wdata_i    (32'h0),
    .outstanding_o (outstanding1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s = %0h", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_wdata = d;
    tick();
    bd_we = 1'b0; bd_idx = '0; bd_wdata = '0;
  endtask

  // Presents one request, checks it is granted, lets it be accepted.
  task automatic issue(input string tag, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    we = w; addr = a; be = b; wdata = d; req = 1'b1;
    #1;
    check_val({tag, "_gnt"}, 64'(gnt), 64'd1);
    tick();
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] d, input logic e);
    check_val({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    check_val({tag, "_rdata"},  64'(rdata),  64'(d));
    check_val({tag, "_err"},    64'(err),    64'(e));
  endtask

  task automatic expect_idle(input string tag);
    check_val({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check_val({tag, "_rdata"},  64'(rdata),  64'd0);
    check_val({tag, "_err"},    64'(err),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [6:0] gnt1_pat;

    rst_ni = 1'b0;
    req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0; stall = 1'b0;
    bd_we = 1'b0; bd_idx = '0; bd_wdata = '0;
    req1 = 1'b0;

    // Reset state (request held high to prove grant is blocked)
    #2;
    expect_idle("rst");
    check_val("rst_outstanding", 64'(outstanding), 64'd0);
    check_val("rst_gnt", 64'(gnt), 64'd0);
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    tick();

    // Preload
    bd_write(10'd5, 32'hDEADBEEF);
    bd_write(10'd3, 32'h11223344);
    bd_write(10'd0, 32'h01020304);

    // Single read, LATENCY=2
    issue("rd5", 1'b0, 32'h14, 4'h0, 32'h0);
    check_val("rd5_early_rvalid", 64'(rvalid), 64'd0);
    check_val("rd5_ost1", 64'(outstanding), 64'd1);
    tick();
    expect_resp("rd5", 32'hDEADBEEF, 1'b0);
    tick();
    expect_idle("rd5_after");
    check_val("rd5_ost0", 64'(outstanding), 64'd0);

    // Partial write then read back
    issue("wr3", 1'b1, 32'h0C, 4'b0101, 32'hAABBCCDD);
    tick();
    expect_resp("wr3", 32'h0, 1'b0);
    tick();
    issue("rd3", 1'b0, 32'h0C, 4'h0, 32'h0);
    tick();
    expect_resp("rd3", 32'h11BB33DD, 1'b0);
    tick();

    // Two back-to-back reads, responses in order
    issue("bb_a", 1'b0, 32'h14, 4'h0, 32'h0);
    issue("bb_b", 1'b0, 32'h0C, 4'h0, 32'h0);
    expect_resp("bb_a", 32'hDEADBEEF, 1'b0);
    check_val("bb_ost2", 64'(outstanding), 64'd2);
    tick();
    expect_resp("bb_b", 32'h11BB33DD, 1'b0);
    check_val("bb_ost1", 64'(outstanding), 64'd1);
    tick();
    expect_idle("bb_after");
    check_val("bb_ost0", 64'(outstanding), 64'd0);

    // Out-of-range write and read; word 0 must not be aliased
    issue("oor_wr", 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    tick();
    expect_resp("oor_wr", 32'h0, 1'b1);
    tick();
    issue("oor_rd", 1'b0, 32'h1000, 4'h0, 32'h0);
    tick();
    expect_resp("oor_rd", 32'h0, 1'b1);
    tick();
    issue("rd0", 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    expect_resp("rd0", 32'h01020304, 1'b0);
    tick();

    // Bus write and backdoor write to the same word on the same edge
    bd_we = 1'b1; bd_idx = 10'd3; bd_wdata = 32'h55667788;
    issue("coll_wr", 1'b1, 32'h0C, 4'hF, 32'h99999999);
    bd_we = 1'b0; bd_idx = '0; bd_wdata = '0;
    tick();
    tick();
    issue("coll_rd", 1'b0, 32'h0C, 4'h0, 32'h0);
    tick();
    expect_resp("coll_rd", 32'h55667788, 1'b0);
    tick();

    // Stall backpressure
    stall = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("stall_gnt%0d", i), 64'(gnt), 64'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    check_val("unstall_gnt", 64'(gnt), 64'd1);
    tick();
    req = 1'b0; addr = '0;
    tick();
    expect_resp("unstall_rd", 32'hDEADBEEF, 1'b0);
    tick();

    // MAX_OUTSTANDING=1: a slot frees only after the retire edge, so the
    // grant cadence with LATENCY=2 is one grant every three cycles.
    gnt1_pat = 7'b1001001;
    pulses = 0;
    req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) req1 = 1'b0;
      #1;
      if (i < 7) check_val($sformatf("lim_gnt%0d", i), 64'(gnt1), 64'(gnt1_pat[i]));
      if (outstanding1 > 1'b1 || (rvalid1 && (rdata1 != 0 || err1))) begin
        check_val($sformatf("lim_state%0d", i), 64'd1, 64'd0);
      end
      if (rvalid1) pulses++;
      tick();
    end
    check_val("lim_pulses", 64'(pulses), 64'd3);
    check_val("lim_ost_end", 64'(outstanding1), 64'd0);

    // Asynchronous reset with two reads in flight
    issue("rr_a", 1'b0, 32'h14, 4'h0, 32'h0);
    issue("rr_b", 1'b0, 32'h0C, 4'h0, 32'h0);
    #2;
    rst_ni = 1'b0;
    req = 1'b1;
    #1;
    expect_idle("arst");
    check_val("arst_ost", 64'(outstanding), 64'd0);
    check_val("arst_gnt", 64'(gnt), 64'd0);
    tick();
    req = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("post_rst_rvalid%0d", i), 64'(rvalid), 64'd0);
      tick();
    end
    issue("keep5", 1'b0, 32'h14, 4'h0, 32'h0);
    tick();
    expect_resp("keep5", 32'hDEADBEEF, 1'b0);
    tick();
    issue("keep0", 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    expect_resp("keep0", 32'h01020304, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
